ram_arbiter: RTL and testbench

- Registered, round-robin arbiter that shares the single RAM port between CPUS cores.
- Each core has one instruction request and one data request.
- Sits between the per-core cache request signals and the RAM. It replaces direct combinational steering with a grant FSM, so only one requester drives the RAM at a time and every core gets fair access.
- Within a core, data requests have priority over instruction requests. A watchdog flags a RAM transaction that never completes.

---
 rtl/ram_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Registered round-robin arbiter sharing one RAM port between
//            CPUS cores. Each core offers a data request (dREN/dWEN) and an
//            instruction request (iREN); data wins within a core. A grant
//            FSM (IDLE -> REQ -> IDLE) lets one requester drive the RAM at a
//            time, and a watchdog pulses err_timeout_o when the RAM never
//            reports ACCESS for the granted transaction.
// Ports    : CLK_i, RST_i            clock, synchronous active-high reset
//            iREN_i, iaddr_i         per-core instruction request / address
//            dREN_i, dWEN_i          per-core data read / write request
//            daddr_i, dstore_i       per-core data address / write value
//            iwait_o, dwait_o        per-core waits, 0 = completes this cycle
//            iload_o, dload_o        per-core load data (copies of ramload_i)
//            ramstate_i, ramload_i   RAM status (FREE/BUSY/ACCESS/ERROR), data
//            ramREN_o, ramWEN_o      RAM read / write enables
//            ramaddr_o, ramstore_o   RAM address / write data
//            grant_valid_o           high while a grant is held (REQ)
//            grant_cpu_o             index of the granted core
//            err_timeout_o           one-cycle watchdog expiry pulse
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int CPUS    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                               CLK_i,
  input  logic                               RST_i,
  input  logic [CPUS-1:0]                    iREN_i,
  input  logic [CPUS-1:0][31:0]              iaddr_i,
  input  logic [CPUS-1:0]                    dREN_i,
  input  logic [CPUS-1:0]                    dWEN_i,
  input  logic [CPUS-1:0][31:0]              daddr_i,
  input  logic [CPUS-1:0][31:0]              dstore_i,
  output logic [CPUS-1:0]                    iwait_o,
  output logic [CPUS-1:0]                    dwait_o,
  output logic [CPUS-1:0][31:0]              iload_o,
  output logic [CPUS-1:0][31:0]              dload_o,
  input  logic [1:0]                         ramstate_i,
  input  logic [31:0]                        ramload_i,
  output logic                               ramREN_o,
  output logic                               ramWEN_o,
  output logic [31:0]                        ramaddr_o,
  output logic [31:0]                        ramstore_o,
  output logic                               grant_valid_o,
  output logic [((CPUS > 1) ? $clog2(CPUS) : 1)-1:0] grant_cpu_o,
  output logic                               err_timeout_o
);

  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  // ramstate_t encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   grant_cpu_q, grant_cpu_d;
  logic            grant_is_data_q, grant_is_data_d;
  logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            err_timeout_q, err_timeout_d;

  logic [CPUS-1:0] w_req;
  logic [CPUS-1:0] w_dreq;
  logic            w_found;
  logic [CW-1:0]   w_pick;
  logic            w_sel_req;
  logic            w_active;
  logic            w_access;
  logic            w_done;
  logic [CW-1:0]   w_next_ptr;

  assign w_req  = iREN_i | dREN_i | dWEN_i;
  assign w_dreq = dREN_i | dWEN_i;

  // Round-robin scan: first requesting core at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < CPUS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= CPUS) begin
        idx = idx - CPUS;
      end
      if (!w_found && w_req[idx]) begin
        w_found = 1'b1;
        w_pick  = idx[CW-1:0];
      end
    end
  end

  // The granted request as seen this cycle; its fall means the requester gave up.
  assign w_sel_req = grant_is_data_q ? w_dreq[grant_cpu_q] : iREN_i[grant_cpu_q];

  // Reset in a REQ cycle kills the transaction at once: the RAM is released
  // and no wait bit drops, even though state_q still reads REQ.
  assign w_active = (state_q == S_REQ) && !RST_i;
  assign w_access = (ramstate_i == RAM_ACCESS);
  assign w_done   = w_active && w_sel_req && w_access;

  assign w_next_ptr = (grant_cpu_q == CW'(CPUS - 1)) ? '0 : grant_cpu_q + CW'(1);

  // RAM steering from the held grant.
  always_comb begin
    ramREN_o   = 1'b0;
    ramWEN_o   = 1'b0;
    ramaddr_o  = '0;
    ramstore_o = '0;
    if (w_active) begin
      if (grant_is_data_q) begin
        ramaddr_o  = daddr_i[grant_cpu_q];
        ramstore_o = dstore_i[grant_cpu_q];
        ramWEN_o   = dWEN_i[grant_cpu_q];
        // A simultaneous read and write resolves to the write.
        ramREN_o   = dREN_i[grant_cpu_q] & ~dWEN_i[grant_cpu_q];
      end else begin
        ramaddr_o  = iaddr_i[grant_cpu_q];
        ramREN_o   = iREN_i[grant_cpu_q];
      end
    end
  end

  // Wait release is combinational in the ACCESS cycle so a grant completes
  // in the same cycle the RAM answers.
  always_comb begin
    iwait_o = '1;
    dwait_o = '1;
    if (w_done) begin
      if (grant_is_data_q) begin
        dwait_o[grant_cpu_q] = 1'b0;
      end else begin
        iwait_o[grant_cpu_q] = 1'b0;
      end
    end
  end

  generate
    for (genvar c = 0; c < CPUS; c++) begin : g_load
      assign iload_o[c] = ramload_i;
      assign dload_o[c] = ramload_i;
    end
  endgenerate

  // Next-state logic. Priority in REQ: completion, abort, watchdog, wait.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_cpu_d     = grant_cpu_q;
    grant_is_data_d = grant_is_data_q;
    wd_cnt_d        = wd_cnt_q;
    err_timeout_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          state_d         = S_REQ;
          grant_cpu_d     = w_pick;
          grant_is_data_d = w_dreq[w_pick];
          wd_cnt_d        = '0;
        end
      end
      S_REQ: begin
        if (w_sel_req && w_access) begin
          state_d  = S_IDLE;
          rr_ptr_d = w_next_ptr;
        end else if (!w_sel_req) begin
          // Abort: the pointer stays so the same core is scanned first again.
          state_d = S_IDLE;
        end else if (wd_cnt_q == WW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
          rr_ptr_d      = w_next_ptr;
        end else if (wd_cnt_q != WW'(TIMEOUT)) begin
          wd_cnt_d = wd_cnt_q + WW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= '0;
      grant_cpu_q     <= '0;
      grant_is_data_q <= 1'b0;
      wd_cnt_q        <= '0;
      err_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_cpu_q     <= grant_cpu_d;
      grant_is_data_q <= grant_is_data_d;
      wd_cnt_q        <= wd_cnt_d;
      err_timeout_q   <= err_timeout_d;
    end
  end

  assign grant_valid_o = (state_q == S_REQ);
  assign grant_cpu_o   = grant_cpu_q;
  assign err_timeout_o = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Directed self-checking bench for ram_arbiter (CPUS=2,
//            TIMEOUT=8). Inputs change 1 ns after each rising edge and
//            outputs are compared 1 ns later, inside the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int CPUS    = 2;
  localparam int TIMEOUT = 8;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic [CPUS-1:0]        iREN, dREN, dWEN;
  logic [CPUS-1:0][31:0]  iaddr, daddr, dstore;
  logic [CPUS-1:0]        iwait, dwait;
  logic [CPUS-1:0][31:0]  iload, dload;
  logic [1:0]             ramstate;
  logic [31:0]            ramload;
  logic                   ramREN, ramWEN;
  logic [31:0]            ramaddr, ramstore;
  logic                   grant_valid;
  logic [0:0]             grant_cpu;
  logic                   err_timeout;

  int vectors    = 0;
  int miscompares = 0;

  ram_arbiter #(.CPUS(CPUS), .TIMEOUT(TIMEOUT)) dut (
    .CLK_i(CLK), .RST_i(RST),
    .iREN_i(iREN), .iaddr_i(iaddr),
    .dREN_i(dREN), .dWEN_i(dWEN), .daddr_i(daddr), .dstore_i(dstore),
    .iwait_o(iwait), .dwait_o(dwait), .iload_o(iload), .dload_o(dload),
    .ramstate_i(ramstate), .ramload_i(ramload),
    .ramREN_o(ramREN), .ramWEN_o(ramWEN), .ramaddr_o(ramaddr), .ramstore_o(ramstore),
    .grant_valid_o(grant_valid), .grant_cpu_o(grant_cpu), .err_timeout_o(err_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int lows0, lows1, g;
    logic [1:0] exp_iw;

    // ---- 1: reset with every request high ----
    RST = 1'b1; iREN = 2'b11; dREN = 2'b11; dWEN = 2'b11;
    iaddr = '0; daddr = '0; dstore = '0; ramstate = FREE; ramload = 32'h0;
    cyc(); #1;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_gvalid", grant_valid, 0);
    chk("rst_err", err_timeout, 0);
    cyc(); RST = 1'b0; #1;
    chk("rst2_gvalid", grant_valid, 0);
    chk("rst2_ramaddr", ramaddr, 0);
    cyc(); #1;
    chk("t1_gvalid", grant_valid, 1);
    chk("t1_gcpu", grant_cpu, 0);
    chk("t1_ramWEN", ramWEN, 1);
    chk("t1_ramREN", ramREN, 0);
    cyc(); iREN = 0; dREN = 0; dWEN = 0; #1;
    chk("t1_hold_gvalid", grant_valid, 1);
    chk("t1_drop_ramWEN", ramWEN, 0);
    chk("t1_drop_dwait", dwait, 2'b11);
    cyc(); #1;
    chk("t1_abort_gvalid", grant_valid, 0);

    // ---- 2: single data read completing on first REQ cycle ----
    dREN = 2'b01; daddr[0] = 32'h100; ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    chk("t2_idle_ramREN", ramREN, 0);
    cyc(); #1;
    chk("t2_ramaddr", ramaddr, 32'h100);
    chk("t2_ramREN", ramREN, 1);
    chk("t2_ramWEN", ramWEN, 0);
    chk("t2_dwait", dwait, 2'b10);
    chk("t2_iwait", iwait, 2'b11);
    chk("t2_dload0", dload[0], 32'hDEADBEEF);
    chk("t2_iload1", iload[1], 32'hDEADBEEF);
    cyc(); dREN = 0; #1;
    chk("t2_idle_gvalid", grant_valid, 0);
    chk("t2_idle_dwait", dwait, 2'b11);

    // Reset between tests so the pointer starts at core 0.
    cyc(); RST = 1'b1; #1;
    cyc(); RST = 1'b0; #1;

    // ---- 3: two instruction requesters alternate ----
    iREN = 2'b11; iaddr[0] = 32'h1000; iaddr[1] = 32'h2000; ramstate = ACCESS; #1;
    chk("t3_c0_gvalid", grant_valid, 0);
    lows0 = 0; lows1 = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 8) iREN = 2'b00;
      #1;
      if (iwait[0] == 1'b0) lows0++;
      if (iwait[1] == 1'b0) lows1++;
      if (k % 2 == 1) begin
        g = ((k - 1) / 2) % 2;
        exp_iw = (g == 0) ? 2'b10 : 2'b01;
        chk("t3_gvalid", grant_valid, 1);
        chk("t3_gcpu", grant_cpu, g);
        chk("t3_iwait", iwait, exp_iw);
        chk("t3_ramaddr", ramaddr, (g == 0) ? 32'h1000 : 32'h2000);
      end else begin
        chk("t3_idle_gvalid", grant_valid, 0);
        chk("t3_idle_iwait", iwait, 2'b11);
      end
    end
    chk("t3_lows0", lows0, 2);
    chk("t3_lows1", lows1, 2);

    // ---- 4: data (write wins) before instruction on the same core ----
    dWEN = 2'b01; dREN = 2'b01; iREN = 2'b01; daddr[0] = 32'h40; dstore[0] = 32'h12345678; #1;
    cyc(); #1;
    chk("t4_ramWEN", ramWEN, 1);
    chk("t4_ramREN", ramREN, 0);
    chk("t4_ramstore", ramstore, 32'h12345678);
    chk("t4_ramaddr", ramaddr, 32'h40);
    chk("t4_dwait", dwait, 2'b10);
    chk("t4_iwait", iwait, 2'b11);
    cyc(); dWEN = 0; dREN = 0; #1;
    chk("t4_idle_gvalid", grant_valid, 0);
    cyc(); #1;
    chk("t4_i_gcpu", grant_cpu, 0);
    chk("t4_i_ramREN", ramREN, 1);
    chk("t4_i_ramWEN", ramWEN, 0);
    chk("t4_i_ramstore", ramstore, 0);
    chk("t4_i_ramaddr", ramaddr, 32'h1000);
    chk("t4_i_iwait", iwait, 2'b10);
    chk("t4_i_dwait", dwait, 2'b11);
    cyc(); iREN = 0; #1;

    // ---- 5: watchdog on core 1 with RAM stuck BUSY ----
    dREN = 2'b10; daddr[1] = 32'h200; ramstate = BUSY; #1;
    for (int j = 1; j <= 8; j++) begin
      cyc(); #1;
      chk("t5_gvalid", grant_valid, 1);
      chk("t5_gcpu", grant_cpu, 1);
      chk("t5_dwait", dwait, 2'b11);
      chk("t5_err_low", err_timeout, 0);
      chk("t5_ramaddr", ramaddr, 32'h200);
    end
    cyc(); dREN = 0; #1;
    chk("t5_err_pulse", err_timeout, 1);
    chk("t5_post_gvalid", grant_valid, 0);
    chk("t5_post_dwait", dwait, 2'b11);
    cyc(); iREN = 2'b11; #1;
    chk("t5_err_once", err_timeout, 0);
    cyc(); #1;
    chk("t5_rr_ptr0", grant_cpu, 0);
    chk("t5_rr_gvalid", grant_valid, 1);

    // ---- 6: abort by dropping iREN, then reset during REQ ----
    chk("t6_busy_iwait", iwait, 2'b11);
    cyc(); iREN = 2'b10; #1;
    chk("t6_drop_gvalid", grant_valid, 1);
    chk("t6_drop_iwait", iwait, 2'b11);
    chk("t6_drop_ramREN", ramREN, 0);
    cyc(); iREN = 2'b11; #1;
    chk("t6_abort_gvalid", grant_valid, 0);
    chk("t6_abort_iwait", iwait, 2'b11);
    cyc(); #1;
    chk("t6_rr_kept", grant_cpu, 0);
    RST = 1'b1; ramstate = ACCESS; #1;
    chk("t6_rst_iwait", iwait, 2'b11);
    chk("t6_rst_ramREN", ramREN, 0);
    cyc(); RST = 1'b0; iREN = 0; ramstate = FREE; #1;
    chk("t6_post_gvalid", grant_valid, 0);
    chk("t6_post_iwait", iwait, 2'b11);
    chk("t6_post_err", err_timeout, 0);
    chk("t6_post_ramaddr", ramaddr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
